ucie_ctl_rx_credit_ctrl: RTL and testbench

- Receive-side credit controller that sequences the RX buffer, which holds NBYTES-wide flits and sits between RDI and FDI.
- Tracks buffer occupancy and credits outstanding at the link partner.
- Paces credit-return pulses toward the TX sideband.
- Gates the buffer enable from the RDI state request and flags credit protocol violations (overflow/underflow).

---
 rtl/ucie_ctl_rx_credit_ctrl_pkg.sv | 22 ++
 rtl/ucie_ctl_rx_credit_pacer.sv | 58 +++++
 rtl/ucie_ctl_rx_credit_ctrl.sv | 110 +++++++++++
 tb/tb_ucie_ctl_rx_credit_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_rx_credit_ctrl_pkg.sv
// Shared UCIe controller definitions: RDI state-request encodings and the
// 2-bit credit-controller state, used by the RX FSM and the TX credit consumer.
`ifndef NBYTES
`define NBYTES 64
`endif

package ucie_ctl_rx_credit_ctrl_pkg;

   localparam logic [3:0] REQ_RESET     = 4'b0000;
   localparam logic [3:0] REQ_ACTIVE    = 4'b0001;
   localparam logic [3:0] REQ_LINKRESET = 4'b1001;
   localparam logic [3:0] REQ_LINKERROR = 4'b1010;
   localparam logic [3:0] REQ_RETRAIN   = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_ERROR  = 2'd3
   } ctl_state_e;

endpackage

// File: rtl/ucie_ctl_rx_credit_pacer.sv
// Holds credits freed by FDI drains and returns them in paced chunks of at
// most RET_MAX, with at least RET_GAP idle cycles between return pulses.
module ucie_ctl_rx_credit_pacer
   import ucie_ctl_rx_credit_ctrl_pkg::*;
#(
   parameter int CREDITS = 32,
   parameter int RET_MAX = 4,
   parameter int RET_GAP = 2,
   localparam int CW = $clog2(CREDITS + 1),
   localparam int RW = $clog2(RET_MAX + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clear,
   input  logic          i_load,
   input  logic          i_run,
   input  logic          i_enable,
   input  logic          i_drain,
   output logic          o_valid,
   output logic [RW-1:0] o_count,
   output logic [CW-1:0] o_pending
);

   localparam int GW = (RET_GAP > 0) ? $clog2(RET_GAP + 1) : 1;
   localparam logic [GW-1:0] GAP_W = GW'(RET_GAP);
   localparam logic [RW-1:0] RET_MAX_W = RW'(RET_MAX);

   logic [CW-1:0] pending;
   logic [GW-1:0] gap;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      o_valid = i_enable && (pending != '0) && (gap == '0);
      o_count = '0;
      if (o_valid)
         o_count = (int'(pending) > RET_MAX) ? RET_MAX_W : RW'(pending);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst || i_clear) begin
         pending <= '0;
         gap     <= '0;
      end else if (i_load) begin
         pending <= CW'(CREDITS);
         gap     <= '0;
      end else if (i_run) begin
         pending <= pending + CW'(i_drain) - CW'(o_count);
         if (o_valid)
            gap <= GAP_W;
         else if (gap != '0)
            gap <= gap - GW'(1);
      end
   end

   assign o_pending = pending;

endmodule

// File: rtl/ucie_ctl_rx_credit_ctrl.sv
// RX credit controller: sequences the RX flit buffer from RDI state requests,
// tracks occupancy/outstanding credits and flags credit protocol violations.
module ucie_ctl_rx_credit_ctrl
   import ucie_ctl_rx_credit_ctrl_pkg::*;
#(
   parameter int NBYTES  = `NBYTES,
   parameter int CREDITS = 32,
   parameter int RET_MAX = 4,
   parameter int RET_GAP = 2,
   localparam int CW = $clog2(CREDITS + 1),
   localparam int RW = $clog2(RET_MAX + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [3:0]    i_state_request,
   input  logic          i_rdi_pl_valid,
   input  logic          i_fdi_drain,
   output logic          o_buffer_enable,
   output logic          o_credit_return_valid,
   output logic [RW-1:0] o_credit_return_count,
   output logic [CW-1:0] o_credits_outstanding,
   output logic [CW-1:0] o_occupancy,
   output logic          o_overflow_detected,
   output logic          o_underflow_detected,
   output logic [1:0]    o_state
);

   ctl_state_e    state;
   logic [CW-1:0] occ, outs, pending;
   logic          ovf_flag, unf_flag;
   logic          counting, clear, load, ovf, unf, eff_valid, eff_drain;
   logic          ret_valid;
   logic [RW-1:0] ret_cnt;

   assign counting  = (state == ST_ACTIVE) || (state == ST_DRAIN);
   assign clear     = (i_state_request == REQ_RESET);
   assign load      = (state == ST_IDLE) && (i_state_request == REQ_ACTIVE);
   assign ovf       = counting && i_rdi_pl_valid &&
                      ((outs == '0) || ((occ == CW'(CREDITS)) && !i_fdi_drain));
   assign unf       = counting && i_fdi_drain && (occ == '0);
   // Offending operations are dropped so counters never wrap.
   assign eff_valid = counting && i_rdi_pl_valid && !ovf;
   assign eff_drain = counting && i_fdi_drain && !unf;

   ucie_ctl_rx_credit_pacer #(
      .CREDITS (CREDITS),
      .RET_MAX (RET_MAX),
      .RET_GAP (RET_GAP)
   ) u_pacer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (clear),
      .i_load    (load),
      .i_run     (counting),
      .i_enable  (state == ST_ACTIVE),
      .i_drain   (eff_drain),
      .o_valid   (ret_valid),
      .o_count   (ret_cnt),
      .o_pending (pending)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst || clear) begin
         state    <= ST_IDLE;
         occ      <= '0;
         outs     <= '0;
         ovf_flag <= 1'b0;
         unf_flag <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load)
                  state <= ST_ACTIVE;
            end
            ST_ACTIVE, ST_DRAIN: begin
               occ      <= occ + CW'(eff_valid) - CW'(eff_drain);
               outs     <= outs + CW'(ret_cnt) - CW'(eff_valid);
               ovf_flag <= ovf_flag | ovf;
               unf_flag <= unf_flag | unf;
               if ((i_state_request == REQ_LINKERROR) || ovf || unf)
                  state <= ST_ERROR;
               else if ((state == ST_ACTIVE) && (i_state_request == REQ_RETRAIN))
                  state <= ST_DRAIN;
               else if ((state == ST_DRAIN) && (occ == '0) &&
                        (i_state_request == REQ_ACTIVE))
                  state <= ST_ACTIVE;
            end
            default: ;
         endcase
      end
   end

   assign o_buffer_enable       = counting;
   assign o_credit_return_valid = ret_valid;
   assign o_credit_return_count = ret_cnt;
   assign o_credits_outstanding = outs;
   assign o_occupancy           = occ;
   assign o_overflow_detected   = ovf_flag;
   assign o_underflow_detected  = unf_flag;
   assign o_state               = state;

   a_bounds: assert property (@(posedge i_clk) disable iff (!i_rst)
      (int'(occ) <= CREDITS) && (int'(outs) <= CREDITS) && (int'(pending) <= CREDITS));

   a_conserve: assert property (@(posedge i_clk) disable iff (!i_rst)
      counting |-> (int'(occ) + int'(outs) + int'(pending) == CREDITS));

   a_nbytes: assert property (@(posedge i_clk) NBYTES > 0);

endmodule

// File: tb/tb_ucie_ctl_rx_credit_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic compared every
// cycle against a behavioural credit-accounting model.
module tb_ucie_ctl_rx_credit_ctrl;

   localparam int CREDITS = 8;
   localparam int RET_MAX = 4;
   localparam int RET_GAP = 2;
   localparam int CW = $clog2(CREDITS + 1);
   localparam int RW = $clog2(RET_MAX + 1);

   localparam logic [3:0] R_RESET     = 4'b0000;
   localparam logic [3:0] R_ACTIVE    = 4'b0001;
   localparam logic [3:0] R_LINKRESET = 4'b1001;
   localparam logic [3:0] R_LINKERROR = 4'b1010;
   localparam logic [3:0] R_RETRAIN   = 4'b1011;

   localparam int M_IDLE = 0, M_ACTIVE = 1, M_DRAIN = 2, M_ERROR = 3;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b0;
   logic [3:0]    i_state_request = R_RESET;
   logic          i_rdi_pl_valid = 1'b0;
   logic          i_fdi_drain = 1'b0;
   logic          o_buffer_enable;
   logic          o_credit_return_valid;
   logic [RW-1:0] o_credit_return_count;
   logic [CW-1:0] o_credits_outstanding;
   logic [CW-1:0] o_occupancy;
   logic          o_overflow_detected;
   logic          o_underflow_detected;
   logic [1:0]    o_state;

   ucie_ctl_rx_credit_ctrl #(
      .NBYTES  (64),
      .CREDITS (CREDITS),
      .RET_MAX (RET_MAX),
      .RET_GAP (RET_GAP)
   ) dut (
      .i_clk                 (i_clk),
      .i_rst                 (i_rst),
      .i_state_request       (i_state_request),
      .i_rdi_pl_valid        (i_rdi_pl_valid),
      .i_fdi_drain           (i_fdi_drain),
      .o_buffer_enable       (o_buffer_enable),
      .o_credit_return_valid (o_credit_return_valid),
      .o_credit_return_count (o_credit_return_count),
      .o_credits_outstanding (o_credits_outstanding),
      .o_occupancy           (o_occupancy),
      .o_overflow_detected   (o_overflow_detected),
      .o_underflow_detected  (o_underflow_detected),
      .o_state               (o_state)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: credits live in exactly one of buffer, partner or pending pool.
   int m_st = M_IDLE, m_occ = 0, m_outs = 0, m_pend = 0, m_gap = 0;
   int m_ovf = 0, m_unf = 0;
   int n_pulses = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic int model_ret();
      if (m_st == M_ACTIVE && m_pend > 0 && m_gap == 0)
         return (m_pend < RET_MAX) ? m_pend : RET_MAX;
      return 0;
   endfunction

   task automatic model_update(input logic rst, input logic [3:0] req,
                               input logic v, input logic d);
      int ret, ovf, unf, vv, dd, old_occ;
      if (!rst || req == R_RESET) begin
         m_st = M_IDLE; m_occ = 0; m_outs = 0; m_pend = 0; m_gap = 0;
         m_ovf = 0; m_unf = 0;
      end else if (m_st == M_IDLE) begin
         if (req == R_ACTIVE) begin
            m_st = M_ACTIVE; m_pend = CREDITS; m_occ = 0; m_outs = 0; m_gap = 0;
         end
      end else if (m_st == M_ACTIVE || m_st == M_DRAIN) begin
         ret = model_ret();
         ovf = (v && (m_outs == 0 || m_occ + 1 - int'(d) > CREDITS)) ? 1 : 0;
         unf = (d && m_occ == 0) ? 1 : 0;
         vv = (v && !ovf) ? 1 : 0;
         dd = (d && !unf) ? 1 : 0;
         old_occ = m_occ;
         m_occ  = m_occ + vv - dd;
         m_outs = m_outs + ret - vv;
         m_pend = m_pend + dd - ret;
         m_gap  = (ret > 0) ? RET_GAP : ((m_gap > 0) ? m_gap - 1 : 0);
         if (ovf) m_ovf = 1;
         if (unf) m_unf = 1;
         if (req == R_LINKERROR || ovf || unf) m_st = M_ERROR;
         else if (m_st == M_ACTIVE && req == R_RETRAIN) m_st = M_DRAIN;
         else if (m_st == M_DRAIN && old_occ == 0 && req == R_ACTIVE) m_st = M_ACTIVE;
      end
   endtask

   task automatic compare_all();
      int r;
      r = model_ret();
      check("state", int'(o_state), m_st);
      check("buffer_enable", int'(o_buffer_enable), (m_st == M_ACTIVE || m_st == M_DRAIN) ? 1 : 0);
      check("ret_valid", int'(o_credit_return_valid), (r > 0) ? 1 : 0);
      check("ret_count", int'(o_credit_return_count), r);
      check("outstanding", int'(o_credits_outstanding), m_outs);
      check("occupancy", int'(o_occupancy), m_occ);
      check("overflow", int'(o_overflow_detected), m_ovf);
      check("underflow", int'(o_underflow_detected), m_unf);
      if (o_credit_return_valid) n_pulses++;
   endtask

   task automatic cycle(input logic rst, input logic [3:0] req,
                        input logic v, input logic d);
      i_rst = rst; i_state_request = req; i_rdi_pl_valid = v; i_fdi_drain = d;
      @(posedge i_clk);
      model_update(rst, req, v, d);
      #1;
      compare_all();
   endtask

   task automatic reset_and_init();
      cycle(1'b0, R_RESET, 1'b0, 1'b0);
      cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
   endtask

   initial begin
      int p0;
      logic v, d, rst;
      logic [3:0] req;
      int rq;

      // Reset state
      cycle(1'b0, R_RESET, 1'b0, 1'b0);
      cycle(1'b0, R_ACTIVE, 1'b1, 1'b1);
      check("reset_state", int'(o_state), 0);
      check("reset_outs", int'(o_credits_outstanding), 0);

      // Init: two returns of 4 separated by two idle cycles
      cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
      check("init_state", int'(o_state), 1);
      check("init_ret1_valid", int'(o_credit_return_valid), 1);
      check("init_ret1_count", int'(o_credit_return_count), 4);
      cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
      check("init_gap1", int'(o_credit_return_valid), 0);
      cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
      check("init_gap2", int'(o_credit_return_valid), 0);
      cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
      check("init_ret2_count", int'(o_credit_return_count), 4);
      cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
      check("init_outs", int'(o_credits_outstanding), 8);

      // Steady flow: 8 valids then 8 drains
      for (int i = 0; i < 8; i++) cycle(1'b1, R_ACTIVE, 1'b1, 1'b0);
      check("flow_peak_occ", int'(o_occupancy), 8);
      p0 = n_pulses;
      for (int i = 0; i < 8; i++) cycle(1'b1, R_ACTIVE, 1'b0, 1'b1);
      check("flow_empty_occ", int'(o_occupancy), 0);
      for (int i = 0; i < 8; i++) cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
      check("flow_outs_restored", int'(o_credits_outstanding), 8);
      check("flow_no_flags", int'(o_overflow_detected) + int'(o_underflow_detected), 0);
      check("flow_pulse_count_min", (n_pulses - p0 >= 2) ? 1 : 0, 1);

      // Overflow: 9th valid with no credit left
      for (int i = 0; i < 9; i++) cycle(1'b1, R_ACTIVE, 1'b1, 1'b0);
      check("ovf_flag", int'(o_overflow_detected), 1);
      check("ovf_state", int'(o_state), 3);
      check("ovf_buf_en", int'(o_buffer_enable), 0);
      check("ovf_occ", int'(o_occupancy), 8);
      cycle(1'b1, R_RESET, 1'b0, 1'b0);
      check("ovf_clear_state", int'(o_state), 0);
      check("ovf_clear_flag", int'(o_overflow_detected), 0);

      // Underflow: drain from an empty buffer
      reset_and_init();
      cycle(1'b1, R_ACTIVE, 1'b0, 1'b1);
      check("unf_flag", int'(o_underflow_detected), 1);
      check("unf_state", int'(o_state), 3);

      // Retrain: occupancy 3, drain in DRAIN without returns, then one return of 3
      reset_and_init();
      for (int i = 0; i < 3; i++) cycle(1'b1, R_ACTIVE, 1'b1, 1'b0);
      cycle(1'b1, R_RETRAIN, 1'b0, 1'b0);
      check("retrain_state", int'(o_state), 2);
      p0 = n_pulses;
      for (int i = 0; i < 3; i++) cycle(1'b1, R_RETRAIN, 1'b0, 1'b1);
      cycle(1'b1, R_RETRAIN, 1'b0, 1'b0);
      check("retrain_no_pulse", n_pulses - p0, 0);
      cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
      check("retrain_back_active", int'(o_state), 1);
      check("retrain_ret_count", int'(o_credit_return_count), 3);

      // Simultaneous valid+drain, then reset mid-DRAIN
      for (int i = 0; i < 4; i++) cycle(1'b1, R_ACTIVE, 1'b0, 1'b0);
      cycle(1'b1, R_ACTIVE, 1'b1, 1'b0);
      cycle(1'b1, R_ACTIVE, 1'b1, 1'b1);
      check("simul_occ", int'(o_occupancy), 1);
      cycle(1'b1, R_RETRAIN, 1'b0, 1'b0);
      cycle(1'b0, R_RETRAIN, 1'b0, 1'b0);
      check("rst_mid_drain_state", int'(o_state), 0);
      check("rst_mid_drain_occ", int'(o_occupancy), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 199) != 0);
         rq = $urandom_range(0, 99);
         if (rq < 70)      req = R_ACTIVE;
         else if (rq < 84) req = R_RETRAIN;
         else if (rq < 87) req = R_RESET;
         else if (rq < 89) req = R_LINKERROR;
         else if (rq < 94) req = R_LINKRESET;
         else              req = 4'($urandom_range(0, 15));
         v = (m_outs > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
         d = (m_occ > 0)  ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
         cycle(rst, req, v, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
